// File: rtl/alu_pkg.sv
// Shared ALU datapath constants and the serial adder state encoding.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 16;
    localparam int unsigned ALU_SLICE = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } add_state_t;

endpackage

// File: rtl/four_bit_adder.sv
// Combinational slice adder: a ripple chain of full_adder cells.
module four_bit_adder
    import alu_pkg::*;
#(
    parameter int unsigned W = ALU_SLICE
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[W];

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the slice adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one SLICE-bit slice per clock, LSB slice first, with a
// registered inter-slice carry and a start/busy/done handshake.
module nibble_serial_adder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned SLICE = ALU_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    add_state_t       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] partial;

    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE-1:0] s_slice;
    logic             c_slice;
    logic [WIDTH-1:0] merged;
    logic             last;

    // Operand slice selected by the counter, and the partial with it merged in.
    always_comb begin
        a_slice = a_reg[cnt*SLICE +: SLICE];
        b_slice = b_reg[cnt*SLICE +: SLICE];
        merged  = partial;
        merged[cnt*SLICE +: SLICE] = s_slice;
        last    = (cnt == CW'(NSLICE - 1));
    end

    four_bit_adder #(
        .W (SLICE)
    ) u_slice_add (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry),
        .sum  (s_slice),
        .cout (c_slice)
    );

    // Handshake FSM; results are published only on the final slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            carry   <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            partial <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    partial[cnt*SLICE +: SLICE] <= s_slice;
                    carry <= c_slice;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum   <= merged;
                        cout  <= c_slice;
                        ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                 (merged[WIDTH-1] != a_reg[WIDTH-1]);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle 16-bit adder for the ALU datapath; the add-direction counterpart of the ripple-borrow subtractor.
- Adds one SLICE-bit slice per clock, LSB slice first, and carries between slices in a registered carry flop.
- Uses a start/busy/done handshake.
- Registered sum, carry-out and signed-overflow results feed the ALU result mux and the flag logic.

Parameters:
- WIDTH, 16, operand and result width in bits.
- SLICE, 4, bits added per cycle; WIDTH must be an integer multiple of SLICE.
- NSLICE, WIDTH/SLICE, derived (localparam), number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  augend; captured when start is accepted.
- b  input  WIDTH  addend; captured when start is accepted.
- cin  input  1  carry-in; captured when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the results update.
- sum  output  WIDTH  registered result.
- cout  output  1  registered carry out of the MSB.
- ovf  output  1  registered two's-complement overflow.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state=IDLE, slice counter=0, carry flop=0, operand and partial registers=0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE, start=1 at an edge:
  - Latch a, b and cin.
  - Set carry flop to cin and counter to 0.
  - Go to RUN. busy=1 from the next cycle.
- RUN, each edge:
  - Compute {c, s} = a_reg[k*SLICE +: SLICE] + b_reg[same] + carry, where k is the counter.
  - Write s into partial[k*SLICE +: SLICE] and c into the carry flop.
  - Increment the counter.
- RUN, edge with k = NSLICE-1:
  - Load sum from partial with the final slice merged in.
  - Set cout to the final carry.
  - Set ovf = (a_reg[MSB] == b_reg[MSB]) && (final sum[MSB] != a_reg[MSB]).
  - Set done=1 for exactly one cycle and return to IDLE (busy=0).
- Latency: start accepted at edge 0; done, sum, cout and ovf are valid after edge NSLICE (4 cycles for the defaults).
- sum, cout and ovf update only at completion. They hold their values until the next completion, so partial sums are never visible.
- start while busy=1 is ignored: no queuing, and the captured operands are not disturbed.
- start in the cycle where done=1 (state is IDLE) is accepted, so operations can run back-to-back with throughput of one result per NSLICE+1 cycles.
- a, b and cin may change freely after acceptance.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the true carry (cin included). ovf follows the signed rule above.
- Reset asserted mid-RUN:
  - The operation aborts immediately (asynchronous) and all outputs return to reset values.
  - No done is produced.
  - After rst_n deasserts, the first start begins a fresh operation.
- No combinational path from any input to any output.

Decomposition:
- Shared package alu_pkg holds:
  - constants ALU_WIDTH=16 and ALU_SLICE=4;
  - state type add_state_t {IDLE, RUN}.
- One sub-module: four_bit_adder, a combinational SLICE-bit adder with ports (a, b, cin, sum, cout), built from full_adder cells.
- The top block holds only the FSM, the counter, the carry flop and the registers.

Test Plan:
- Basic add: a=0x1234, b=0x1111, cin=0, start pulsed -> busy high for 4 cycles; done high after edge 4; sum=0x2345, cout=0, ovf=0.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Carry must propagate across all 4 slices.
- Signed overflow with carry-in: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0. Then a=0x00FF, b=0x0000, cin=1 -> sum=0x0100, cout=0, ovf=0.
- Handshake: start during busy with a=0xAAAA -> ignored, first result unchanged. Then start held high in the done cycle -> second operation accepted and completes 5 cycles after the first done.
- Reset mid-op: start, then drop rst_n after 2 RUN cycles -> busy, done, sum, cout and ovf go to 0 asynchronously with no done pulse. A new start after release produces the correct result.
